lsu_sram_master: RTL and testbench
==================================

Name: lsu_sram_master

Overview:
- Requester-side bridge between the CPU load/store unit and the 32-bit SRAM controller's LSU port.
- Converts byte-addressed load/store requests (byte/half/word, signed/unsigned) into single-cycle controller strobes with a lane byte mask.
- Holds the CPU pipeline stalled until the controller acks, then returns lane-extracted, sign- or zero-extended load data.
- Adds misalignment detection and an ack timeout.

Parameters:
TIMEOUT_CYCLES, 15, cycles spent in WAIT without i_sram_ack before the access is aborted with o_timeout (legal range 4..255).

Ports:
i_clk  in  1  clock
i_reset  in  1  reset, synchronous, active-low
i_lsu_addr  in  32  byte address; bits [18:0] used, upper bits ignored
i_lsu_wdata  in  32  store data, right-aligned
i_lsu_size  in  2  00 byte, 01 half, 10 word, 11 illegal
i_lsu_unsigned  in  1  1 = zero-extend load, 0 = sign-extend
i_lsu_wren  in  1  store request, held stable while o_lsu_stall=1
i_lsu_rden  in  1  load request, held stable while o_lsu_stall=1
o_lsu_rdata  out  32  extended load data, valid when o_lsu_done=1
o_lsu_stall  out  1  pipeline stall
o_lsu_done  out  1  one-cycle completion pulse
o_misaligned  out  1  with done: access was misaligned or illegal
o_timeout  out  1  with done: controller never acked
o_sram_addr  out  18  halfword address {addr[18:2],1'b0}, registered
o_sram_wdata  out  32  lane-replicated store data, registered
o_sram_bmask  out  4  byte-lane mask, registered, driven on loads and stores
o_sram_wren  out  1  one-cycle write strobe
o_sram_rden  out  1  one-cycle read strobe
i_sram_rdata  in  32  controller read data, valid with ack
i_sram_ack  in  1  controller completion pulse

Behaviour:
- Reset (i_reset=0 at posedge): state IDLE. All outputs are 0, including addr, wdata, bmask, rdata and the timeout counter. The controller shares this reset; reset mid-access abandons it with no done pulse.
- States: IDLE, REQ, WAIT, DONE.
- IDLE, valid request (exactly one of wren/rden):
  - Aligned: register addr, mask, wdata, size, unsigned, direction; go to REQ.
  - Misaligned or size=11: go to DONE with the misaligned flag set; no SRAM access.
- IDLE, wren=rden (both 0 or both 1): no action, no stall.
- IDLE, any i_sram_ack: ignored.
- REQ:
  - Assert exactly one of o_sram_wren/o_sram_rden for this single cycle.
  - Go to WAIT; clear the timeout counter.
  - Any i_sram_ack in this cycle is ignored.
- WAIT:
  - On i_sram_ack: capture i_sram_rdata if a load; go to DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES-1 without ack, go to DONE with timeout set and rdata 0.
- DONE:
  - o_lsu_done=1 and o_lsu_stall=0.
  - o_misaligned/o_timeout reflect the latched flags.
  - Next state is IDLE; requests present during DONE are not sampled.
- o_lsu_stall = (IDLE and valid and not misaligned) or REQ or WAIT. Combinational from state and request.
- Alignment:
  - Half requires a[0]=0.
  - Word requires a[1:0]=00.
- Mask (a = addr[1:0]):
  - Byte: 1<<a.
  - Half: a[1] ? 1100 : 0011.
  - Word: 1111.
- Store data:
  - Byte: {4{wdata[7:0]}}.
  - Half: {2{wdata[15:0]}}.
  - Word: wdata unchanged.
- Load data:
  - Shift the captured word right by 8*a.
  - Byte: take bits [7:0]; half: take bits [15:0].
  - Extend per i_lsu_unsigned.
  - Misaligned or timeout: o_lsu_rdata=0.
- Latency (request seen in IDLE at cycle T; controller adds 2 cycles for writes, 3 for reads):
  - Store: strobe at T+1, ack at T+3, done at T+4 (stall T..T+3).
  - Load: strobe at T+1, ack at T+4, done at T+5 (stall T..T+4).
  - Misaligned: done at T+1, no stall.

Test Plan:
- Store word: addr 0x0000_0104, data 0xDEADBEEF, wren. Expect a single wren pulse at T+1 with o_sram_addr=0x00082, bmask=1111, wdata=0xDEADBEEF. Expect done at T+4 and stall high for exactly 4 cycles.
- Load byte signed: SRAM word at 0x100 = 0x80FF7F01, addr 0x103, size 00, unsigned=0. Expect bmask=1000, rdata 0xFFFFFF80. Repeat with unsigned=1: expect 0x00000080.
- Store half at addr 0x206, data 0x0000ABCD. Expect bmask=1100, wdata=0xABCDABCD. A subsequent load half unsigned at 0x206 returns 0x0000ABCD.
- Misaligned: word load at 0x101 and half store at 0x203. Expect no sram strobe, done with o_misaligned=1 at T+1, rdata 0.
- Timeout: i_sram_ack tied 0, load at 0x0. Expect done with o_timeout=1 after TIMEOUT_CYCLES WAIT cycles and rdata 0. A stray ack in IDLE afterward causes no state change.
- Reset mid-load: assert i_reset=0 during WAIT. Next cycle all outputs are 0 and state is IDLE, with no done pulse. After release, wren=rden=1 yields no strobe and no stall.

Source files
------------

// File: rtl/lsu_sram_master_if.sv
// LSU request / SRAM controller bundle for lsu_sram_master.
// master is the bridge view, slave is the CPU + controller view.
interface lsu_sram_master_if;
   logic [31:0] i_lsu_addr;
   logic [31:0] i_lsu_wdata;
   logic [1:0]  i_lsu_size;
   logic        i_lsu_unsigned;
   logic        i_lsu_wren;
   logic        i_lsu_rden;
   logic [31:0] o_lsu_rdata;
   logic        o_lsu_stall;
   logic        o_lsu_done;
   logic        o_misaligned;
   logic        o_timeout;
   logic [17:0] o_sram_addr;
   logic [31:0] o_sram_wdata;
   logic [3:0]  o_sram_bmask;
   logic        o_sram_wren;
   logic        o_sram_rden;
   logic [31:0] i_sram_rdata;
   logic        i_sram_ack;

   modport master (
      input  i_lsu_addr,
      input  i_lsu_wdata,
      input  i_lsu_size,
      input  i_lsu_unsigned,
      input  i_lsu_wren,
      input  i_lsu_rden,
      output o_lsu_rdata,
      output o_lsu_stall,
      output o_lsu_done,
      output o_misaligned,
      output o_timeout,
      output o_sram_addr,
      output o_sram_wdata,
      output o_sram_bmask,
      output o_sram_wren,
      output o_sram_rden,
      input  i_sram_rdata,
      input  i_sram_ack
   );

   modport slave (
      output i_lsu_addr,
      output i_lsu_wdata,
      output i_lsu_size,
      output i_lsu_unsigned,
      output i_lsu_wren,
      output i_lsu_rden,
      input  o_lsu_rdata,
      input  o_lsu_stall,
      input  o_lsu_done,
      input  o_misaligned,
      input  o_timeout,
      input  o_sram_addr,
      input  o_sram_wdata,
      input  o_sram_bmask,
      input  o_sram_wren,
      input  o_sram_rden,
      output i_sram_rdata,
      output i_sram_ack
   );
endinterface

// File: rtl/lsu_sram_master.sv
// LSU to SRAM-controller bridge: lane masking, load extension,
// misalignment detection and ack timeout.
module lsu_sram_master #(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic i_clk,
   input  logic i_reset,
   lsu_sram_master_if.master bus
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      DONE
   } state_t;

   localparam logic [7:0] TLAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state;
   logic [7:0]  tcnt;
   logic [1:0]  r_off;
   logic [1:0]  r_size;
   logic        r_uns;
   logic        r_wr;

   logic        req_valid;
   logic [1:0]  a;
   logic        aligned;
   logic [3:0]  mask;
   logic [31:0] wlane;
   logic [31:0] shifted;
   logic [31:0] ext;
   logic        unused_addr;

   assign req_valid = bus.i_lsu_wren ^ bus.i_lsu_rden;
   assign a = bus.i_lsu_addr[1:0];
   assign unused_addr = ^bus.i_lsu_addr[31:19];

   always_comb begin
      aligned = 1'b0;
      mask    = 4'b0000;
      wlane   = bus.i_lsu_wdata;
      unique case (bus.i_lsu_size)
         2'b00: begin
            aligned = 1'b1;
            mask    = 4'b0001 << a;
            wlane   = {4{bus.i_lsu_wdata[7:0]}};
         end
         2'b01: begin
            aligned = ~a[0];
            mask    = a[1] ? 4'b1100 : 4'b0011;
            wlane   = {2{bus.i_lsu_wdata[15:0]}};
         end
         2'b10: begin
            aligned = (a == 2'b00);
            mask    = 4'b1111;
         end
         default: begin
            aligned = 1'b0;
         end
      endcase
   end

   // Lane extraction works straight off the ack cycle's read data.
   assign shifted = bus.i_sram_rdata >> {r_off, 3'b000};

   always_comb begin
      ext = shifted;
      unique case (r_size)
         2'b00:   ext = {{24{~r_uns & shifted[7]}}, shifted[7:0]};
         2'b01:   ext = {{16{~r_uns & shifted[15]}}, shifted[15:0]};
         default: ext = shifted;
      endcase
   end

   assign bus.o_lsu_stall = (state == IDLE && req_valid && aligned)
                          || state == REQ
                          || state == WAIT;

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         state            <= IDLE;
         tcnt             <= '0;
         r_off            <= '0;
         r_size           <= '0;
         r_uns            <= 1'b0;
         r_wr             <= 1'b0;
         bus.o_lsu_rdata  <= '0;
         bus.o_lsu_done   <= 1'b0;
         bus.o_misaligned <= 1'b0;
         bus.o_timeout    <= 1'b0;
         bus.o_sram_addr  <= '0;
         bus.o_sram_wdata <= '0;
         bus.o_sram_bmask <= '0;
         bus.o_sram_wren  <= 1'b0;
         bus.o_sram_rden  <= 1'b0;
      end else begin
         bus.o_sram_wren <= 1'b0;
         bus.o_sram_rden <= 1'b0;
         bus.o_lsu_done  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  if (aligned) begin
                     bus.o_sram_addr  <= {bus.i_lsu_addr[18:2], 1'b0};
                     bus.o_sram_bmask <= mask;
                     bus.o_sram_wdata <= wlane;
                     bus.o_sram_wren  <= bus.i_lsu_wren;
                     bus.o_sram_rden  <= bus.i_lsu_rden;
                     r_off            <= a;
                     r_size           <= bus.i_lsu_size;
                     r_uns            <= bus.i_lsu_unsigned;
                     r_wr             <= bus.i_lsu_wren;
                     state            <= REQ;
                  end else begin
                     bus.o_lsu_done   <= 1'b1;
                     bus.o_misaligned <= 1'b1;
                     bus.o_lsu_rdata  <= '0;
                     state            <= DONE;
                  end
               end
            end
            REQ: begin
               tcnt  <= '0;
               state <= WAIT;
            end
            WAIT: begin
               if (bus.i_sram_ack) begin
                  bus.o_lsu_rdata <= r_wr ? 32'h0 : ext;
                  bus.o_lsu_done  <= 1'b1;
                  state           <= DONE;
               end else if (tcnt == TLAST) begin
                  bus.o_timeout   <= 1'b1;
                  bus.o_lsu_rdata <= '0;
                  bus.o_lsu_done  <= 1'b1;
                  state           <= DONE;
               end else begin
                  tcnt <= tcnt + 8'd1;
               end
            end
            DONE: begin
               bus.o_misaligned <= 1'b0;
               bus.o_timeout    <= 1'b0;
               bus.o_lsu_rdata  <= '0;
               state            <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_sram_master.sv
// Directed bench for lsu_sram_master with a small SRAM controller model.
// Controller acks 2 cycles after a write strobe, 3 after a read strobe.
module tb_lsu_sram_master;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   lsu_sram_master_if bus ();

   lsu_sram_master #(.TIMEOUT_CYCLES(15)) dut (
      .i_clk   (clk),
      .i_reset (rst_n),
      .bus     (bus)
   );

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   logic [31:0] mem [int];
   logic [31:0] w;
   logic [31:0] rword = '0;
   int          cnt = 0;
   int          idx;
   logic        ack_en = 1'b1;
   logic        stray = 1'b0;

   always @(posedge clk) begin
      idx = int'(bus.o_sram_addr[17:1]);
      if (!rst_n) begin
         cnt <= 0;
      end else if (bus.o_sram_wren) begin
         cnt <= 2;
         w = mem.exists(idx) ? mem[idx] : 32'h0;
         for (int b = 0; b < 4; b++)
            if (bus.o_sram_bmask[b]) w[8*b +: 8] = bus.o_sram_wdata[8*b +: 8];
         mem[idx] = w;
      end else if (bus.o_sram_rden) begin
         cnt   <= 3;
         rword <= mem.exists(idx) ? mem[idx] : 32'h0;
      end else if (cnt != 0) begin
         cnt <= cnt - 1;
      end
   end

   assign bus.i_sram_ack   = (ack_en && cnt == 1) || stray;
   assign bus.i_sram_rdata = (cnt == 1) ? rword : 32'h0;

   int          r_strobe_k, r_done_k, r_stall_n, r_strobe_n;
   logic        r_wrs, r_mis, r_to;
   logic [17:0] r_addr;
   logic [3:0]  r_mask;
   logic [31:0] r_wd, r_rdata;

   task automatic access(input logic [31:0] ad, input logic [31:0] d,
                         input logic [1:0] sz, input logic u,
                         input logic wr, input logic rd);
      @(negedge clk);
      bus.i_lsu_addr     = ad;
      bus.i_lsu_wdata    = d;
      bus.i_lsu_size     = sz;
      bus.i_lsu_unsigned = u;
      bus.i_lsu_wren     = wr;
      bus.i_lsu_rden     = rd;
      r_strobe_k = -1; r_done_k = -1; r_stall_n = 0; r_strobe_n = 0;
      r_wrs = 0; r_mis = 0; r_to = 0;
      r_addr = '0; r_mask = '0; r_wd = '0; r_rdata = 32'hxxxx_xxxx;
      #1;
      for (int k = 0; k < 60; k++) begin
         if (k > 0) begin
            @(negedge clk);
            #1;
         end
         if (bus.o_lsu_stall) r_stall_n++;
         if (bus.o_sram_wren || bus.o_sram_rden) begin
            r_strobe_n++;
            r_strobe_k = k;
            r_wrs  = bus.o_sram_wren;
            r_addr = bus.o_sram_addr;
            r_mask = bus.o_sram_bmask;
            r_wd   = bus.o_sram_wdata;
         end
         if (bus.o_lsu_done) begin
            r_done_k = k;
            r_rdata  = bus.o_lsu_rdata;
            r_mis    = bus.o_misaligned;
            r_to     = bus.o_timeout;
            break;
         end
      end
      bus.i_lsu_wren = 1'b0;
      bus.i_lsu_rden = 1'b0;
      if (r_done_k < 0) check("done_seen", 32'(r_done_k), 32'd0);
   endtask

   task automatic idle_watch(input int n, output int strobes,
                             output int dones, output int stalls);
      strobes = 0; dones = 0; stalls = 0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         #1;
         if (bus.o_sram_wren || bus.o_sram_rden) strobes++;
         if (bus.o_lsu_done) dones++;
         if (bus.o_lsu_stall) stalls++;
      end
   endtask

   int s_n, d_n, st_n;

   initial begin
      bus.i_lsu_addr = '0;
      bus.i_lsu_wdata = '0;
      bus.i_lsu_size = '0;
      bus.i_lsu_unsigned = 1'b0;
      bus.i_lsu_wren = 1'b0;
      bus.i_lsu_rden = 1'b0;
      mem[32'h40] = 32'h80FF_7F01;

      repeat (3) @(negedge clk);
      #1;
      check("rst_ctl", {4'h0, bus.o_sram_addr, bus.o_sram_bmask,
            bus.o_sram_wren, bus.o_sram_rden, bus.o_lsu_stall,
            bus.o_lsu_done, bus.o_misaligned, bus.o_timeout}, 32'h0);
      check("rst_rdata", bus.o_lsu_rdata, 32'h0);
      check("rst_wdata", bus.o_sram_wdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      access(32'h0000_0104, 32'hDEAD_BEEF, 2'b10, 1'b0, 1'b1, 1'b0);
      check("sw_strobe_k", 32'(r_strobe_k), 32'd1);
      check("sw_strobe_n", 32'(r_strobe_n), 32'd1);
      check("sw_is_wr", 32'(r_wrs), 32'd1);
      check("sw_addr", 32'(r_addr), 32'h82);
      check("sw_mask", 32'(r_mask), 32'hF);
      check("sw_wdata", r_wd, 32'hDEAD_BEEF);
      check("sw_done_k", 32'(r_done_k), 32'd4);
      check("sw_stall_n", 32'(r_stall_n), 32'd4);
      check("sw_flags", {r_mis, r_to}, 32'h0);

      access(32'h0000_0103, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1);
      check("lbs_is_wr", 32'(r_wrs), 32'd0);
      check("lbs_addr", 32'(r_addr), 32'h80);
      check("lbs_mask", 32'(r_mask), 32'h8);
      check("lbs_done_k", 32'(r_done_k), 32'd5);
      check("lbs_stall_n", 32'(r_stall_n), 32'd5);
      check("lbs_rdata", r_rdata, 32'hFFFF_FF80);

      access(32'h0000_0103, 32'h0, 2'b00, 1'b1, 1'b0, 1'b1);
      check("lbu_rdata", r_rdata, 32'h0000_0080);

      access(32'h0000_0101, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1);
      check("lb1_mask", 32'(r_mask), 32'h2);
      check("lb1_rdata", r_rdata, 32'h0000_007F);

      access(32'h0000_0102, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1);
      check("lb2_rdata", r_rdata, 32'hFFFF_FFFF);

      access(32'h0000_0206, 32'h0000_ABCD, 2'b01, 1'b0, 1'b1, 1'b0);
      check("sh_addr", 32'(r_addr), 32'h102);
      check("sh_mask", 32'(r_mask), 32'hC);
      check("sh_wdata", r_wd, 32'hABCD_ABCD);
      check("sh_done_k", 32'(r_done_k), 32'd4);

      access(32'h0000_0206, 32'h0, 2'b01, 1'b1, 1'b0, 1'b1);
      check("lhu_mask", 32'(r_mask), 32'hC);
      check("lhu_rdata", r_rdata, 32'h0000_ABCD);

      access(32'h0000_0104, 32'h0, 2'b01, 1'b0, 1'b0, 1'b1);
      check("lhs_mask", 32'(r_mask), 32'h3);
      check("lhs_rdata", r_rdata, 32'hFFFF_BEEF);

      access(32'h0000_0104, 32'h0, 2'b10, 1'b0, 1'b0, 1'b1);
      check("lw_rdata", r_rdata, 32'hDEAD_BEEF);

      access(32'h0000_0101, 32'h0, 2'b10, 1'b0, 1'b0, 1'b1);
      check("mlw_done_k", 32'(r_done_k), 32'd1);
      check("mlw_strobe_n", 32'(r_strobe_n), 32'd0);
      check("mlw_stall_n", 32'(r_stall_n), 32'd0);
      check("mlw_flags", {r_mis, r_to}, 32'h2);
      check("mlw_rdata", r_rdata, 32'h0);

      access(32'h0000_0203, 32'h1234, 2'b01, 1'b0, 1'b1, 1'b0);
      check("msh_done_k", 32'(r_done_k), 32'd1);
      check("msh_strobe_n", 32'(r_strobe_n), 32'd0);
      check("msh_flags", {r_mis, r_to}, 32'h2);

      access(32'h0000_0100, 32'h0, 2'b11, 1'b0, 1'b0, 1'b1);
      check("ill_done_k", 32'(r_done_k), 32'd1);
      check("ill_strobe_n", 32'(r_strobe_n), 32'd0);
      check("ill_flags", {r_mis, r_to}, 32'h2);

      ack_en = 1'b0;
      access(32'h0000_0000, 32'h0, 2'b10, 1'b0, 1'b0, 1'b1);
      ack_en = 1'b1;
      check("to_strobe_k", 32'(r_strobe_k), 32'd1);
      check("to_done_k", 32'(r_done_k), 32'd17);
      check("to_stall_n", 32'(r_stall_n), 32'd17);
      check("to_flags", {r_mis, r_to}, 32'h1);
      check("to_rdata", r_rdata, 32'h0);

      @(negedge clk);
      stray = 1'b1;
      @(negedge clk);
      stray = 1'b0;
      idle_watch(4, s_n, d_n, st_n);
      check("stray_activity", 32'(s_n + d_n + st_n), 32'd0);

      @(negedge clk);
      bus.i_lsu_addr = 32'h0000_0100;
      bus.i_lsu_size = 2'b10;
      bus.i_lsu_rden = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("rml_in_wait", 32'(bus.o_lsu_stall), 32'd1);
      rst_n = 1'b0;
      bus.i_lsu_rden = 1'b0;
      @(negedge clk);
      #1;
      check("rml_ctl", {4'h0, bus.o_sram_addr, bus.o_sram_bmask,
            bus.o_sram_wren, bus.o_sram_rden, bus.o_lsu_stall,
            bus.o_lsu_done, bus.o_misaligned, bus.o_timeout}, 32'h0);
      check("rml_rdata", bus.o_lsu_rdata, 32'h0);
      check("rml_wdata", bus.o_sram_wdata, 32'h0);
      rst_n = 1'b1;
      idle_watch(4, s_n, d_n, st_n);
      check("rml_no_done", 32'(d_n), 32'd0);
      bus.i_lsu_wren = 1'b1;
      bus.i_lsu_rden = 1'b1;
      idle_watch(4, s_n, d_n, st_n);
      check("both_strobe", 32'(s_n), 32'd0);
      check("both_stall", 32'(st_n), 32'd0);
      check("both_done", 32'(d_n), 32'd0);
      bus.i_lsu_wren = 1'b0;
      bus.i_lsu_rden = 1'b0;

      access(32'h0000_0104, 32'h0, 2'b10, 1'b0, 1'b0, 1'b1);
      check("post_lw_rdata", r_rdata, 32'hDEAD_BEEF);
      check("post_lw_done_k", 32'(r_done_k), 32'd5);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
